// File: rtl/spi_frame_controller.sv
// SPI mode-0 frame decoder: command word (address + R/W) then one data word.
// Writes produce a one-cycle strobe; reads fetch a word from memory and shift it out on MISO.
module spi_frame_controller #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_cond,
   input  logic                  sclk_posedge,
   input  logic                  sclk_negedge,
   input  logic                  mosi_cond,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  miso,
   output logic                  miso_oe,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   output logic                  rd_req
);

   // The final bit of each word is taken straight from mosi_cond / rd_data, so the
   // shift register only has to hold the bits that precede it.
   localparam int unsigned ShiftWidth =
      (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
   localparam int unsigned MaxBits =
      (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
   localparam int unsigned CntWidth = $clog2(MaxBits + 1);
   localparam logic [CntWidth-1:0] CmdLast  = CntWidth'(ADDR_WIDTH);
   localparam logic [CntWidth-1:0] DataLast = CntWidth'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StGetCmd,
      StReadReq,
      StReadLoad,
      StReadShift,
      StGetData,
      StWrite,
      StDone
   } state_e;

   state_e                  state_q;
   logic [ShiftWidth-1:0]   shift_q;
   logic [CntWidth-1:0]     cnt_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wr_data_q;
   logic                    wr_en_q;
   logic                    rd_req_q;
   logic                    miso_q;
   logic                    miso_oe_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_req_q  <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
      end else begin
         wr_en_q  <= 1'b0;
         rd_req_q <= 1'b0;
         if (cs_cond) begin
            state_q   <= StIdle;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_q <= StGetCmd;
                  cnt_q   <= '0;
               end
               StGetCmd: begin
                  if (sclk_posedge) begin
                     shift_q <= {shift_q[ShiftWidth-2:0], mosi_cond};
                     cnt_q   <= cnt_q + 1'b1;
                     if (cnt_q == CmdLast) begin
                        addr_q <= shift_q[ADDR_WIDTH-1:0];
                        cnt_q  <= '0;
                        if (mosi_cond) begin
                           state_q  <= StReadReq;
                           rd_req_q <= 1'b1;
                        end else begin
                           state_q <= StGetData;
                        end
                     end
                  end
               end
               StReadReq: state_q <= StReadLoad;
               StReadLoad: begin
                  shift_q   <= ShiftWidth'(rd_data[DATA_WIDTH-2:0]);
                  miso_q    <= rd_data[DATA_WIDTH-1];
                  miso_oe_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StReadShift;
               end
               StReadShift: begin
                  if (sclk_negedge) begin
                     shift_q <= shift_q << 1;
                     cnt_q   <= cnt_q + 1'b1;
                     if (cnt_q == DataLast) begin
                        state_q   <= StDone;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                     end else begin
                        miso_q <= shift_q[DATA_WIDTH-2];
                     end
                  end
               end
               StGetData: begin
                  if (sclk_posedge) begin
                     shift_q <= {shift_q[ShiftWidth-2:0], mosi_cond};
                     cnt_q   <= cnt_q + 1'b1;
                     if (cnt_q == DataLast) begin
                        wr_data_q <= {shift_q[DATA_WIDTH-2:0], mosi_cond};
                        wr_en_q   <= 1'b1;
                        state_q   <= StWrite;
                     end
                  end
               end
               StWrite: state_q <= StDone;
               StDone:  state_q <= StDone;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign miso    = miso_q;
   assign miso_oe = miso_oe_q;
   assign addr    = addr_q;
   assign wr_data = wr_data_q;
   assign wr_en   = wr_en_q;
   assign rd_req  = rd_req_q;

endmodule

// File: tb/tb_spi_frame_controller.sv
// Randomised frame-level bench for spi_frame_controller with a behavioural memory and
// a reference memory image updated per completed write frame.
module tb_spi_frame_controller;

   localparam int AW = 7;
   localparam int DW = 8;
   localparam int H  = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cs_cond;
   logic          sclk_posedge;
   logic          sclk_negedge;
   logic          mosi_cond;
   logic [DW-1:0] rd_data;
   logic          miso;
   logic          miso_oe;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_data;
   logic          wr_en;
   logic          rd_req;

   int n_checks = 0;
   int n_errors = 0;

   int wr_cnt = 0;
   int rd_cnt = 0;
   int oe_cycles = 0;
   int bad_miso = 0;
   logic [AW-1:0] wr_addr_seen = '0;
   logic [AW-1:0] rd_addr_seen = '0;
   logic [DW-1:0] wr_data_seen = '0;

   logic [DW-1:0] mem     [2**AW];
   logic [DW-1:0] ref_mem [2**AW];
   logic          mem_init;

   always #5 clk = ~clk;

   spi_frame_controller #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .cs_cond      (cs_cond),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .mosi_cond    (mosi_cond),
      .rd_data      (rd_data),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .addr         (addr),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .rd_req       (rd_req)
   );

   // Synchronous memory: read data valid one cycle after rd_req.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(i * 37 + 11);
         rd_data <= '0;
      end else begin
         if (wr_en) mem[addr] <= wr_data;
         if (rd_req) rd_data <= mem[addr];
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= addr;
            wr_data_seen <= wr_data;
         end
         if (rd_req) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_seen <= addr;
         end
         if (miso_oe) oe_cycles <= oe_cycles + 1;
         if (!miso_oe && miso) bad_miso <= bad_miso + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One SCLK period: low phase, rising-edge pulse, then falling-edge pulse.
   task automatic send_bit(input logic b, input bit both, output logic s);
      mosi_cond = b;
      repeat (H) tick();
      s = miso;
      sclk_posedge = 1'b1;
      sclk_negedge = both;
      tick();
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
   endtask

   task automatic run_frame(input string tag, input bit rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit both, input int extra);
      int wr0 = wr_cnt;
      int rd0 = rd_cnt;
      int oe0 = oe_cycles;
      logic [AW:0]   cmd;
      logic [DW-1:0] rx;
      logic          s;
      cmd = {a, rw};
      cs_cond = 1'b0;
      tick();
      for (int i = AW; i >= 0; i--) send_bit(cmd[i], both, s);
      for (int i = DW - 1; i >= 0; i--) begin
         send_bit(rw ? 1'b0 : d[i], 1'b0, s);
         rx[i] = s;
      end
      repeat (2) tick();
      check({tag, ":oe_end"}, 32'(miso_oe), 32'd0);
      for (int i = 0; i < extra; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, s);
      check({tag, ":wr_pulses"}, 32'(wr_cnt - wr0), rw ? 32'd0 : 32'd1);
      check({tag, ":rd_pulses"}, 32'(rd_cnt - rd0), rw ? 32'd1 : 32'd0);
      if (rw) begin
         check({tag, ":rd_addr"}, 32'(rd_addr_seen), 32'(a));
         check({tag, ":miso_word"}, 32'(rx), 32'(ref_mem[a]));
         check({tag, ":oe_active"}, 32'(oe_cycles != oe0), 32'd1);
      end else begin
         check({tag, ":wr_addr"}, 32'(wr_addr_seen), 32'(a));
         check({tag, ":wr_data"}, 32'(wr_data_seen), 32'(d));
         check({tag, ":wr_data_hold"}, 32'(wr_data), 32'(d));
         check({tag, ":oe_quiet"}, 32'(oe_cycles - oe0), 32'd0);
         ref_mem[a] = d;
      end
      cs_cond = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      logic s;
      int   wr0;
      reset        = 1'b1;
      mem_init     = 1'b1;
      cs_cond      = 1'b1;
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b0;
      mosi_cond    = 1'b0;
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = DW'(i * 37 + 11);
      repeat (2) tick();
      check("rst:miso", 32'(miso), 32'd0);
      check("rst:miso_oe", 32'(miso_oe), 32'd0);
      check("rst:wr_en", 32'(wr_en), 32'd0);
      check("rst:rd_req", 32'(rd_req), 32'd0);
      check("rst:addr", 32'(addr), 32'd0);
      check("rst:wr_data", 32'(wr_data), 32'd0);
      mem_init = 1'b0;
      reset    = 1'b0;
      tick();

      run_frame("wr2a", 1'b0, 7'h2A, 8'hC3, 1'b0, 0);
      run_frame("wr15", 1'b0, 7'h15, 8'h96, 1'b0, 0);
      run_frame("rd15", 1'b1, 7'h15, 8'h00, 1'b0, 0);

      // Abort after five data bits of a write.
      wr0 = wr_cnt;
      cs_cond = 1'b0;
      tick();
      for (int i = AW; i >= 0; i--) send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0, s);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, s);
      cs_cond = 1'b1;
      repeat (2) tick();
      check("abort:no_wr", 32'(wr_cnt - wr0), 32'd0);
      run_frame("wr01", 1'b0, 7'h01, 8'hFF, 1'b0, 0);

      // Reset while shifting read data.
      cs_cond = 1'b0;
      tick();
      for (int i = AW; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'(7'h15 >> (i - 1)), 1'b0, s);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, s);
      reset = 1'b1;
      tick();
      check("midrst:miso", 32'(miso), 32'd0);
      check("midrst:miso_oe", 32'(miso_oe), 32'd0);
      check("midrst:addr", 32'(addr), 32'd0);
      check("midrst:wr_data", 32'(wr_data), 32'd0);
      reset   = 1'b0;
      cs_cond = 1'b1;
      repeat (2) tick();
      run_frame("rd15b", 1'b1, 7'h15, 8'h00, 1'b0, 0);

      run_frame("done_edges", 1'b0, 7'h6C, 8'h5A, 1'b0, 4);
      run_frame("both_edges", 1'b0, 7'h55, 8'h3C, 1'b1, 0);
      run_frame("both_rd", 1'b1, 7'h55, 8'h00, 1'b1, 0);

      for (int k = 0; k < 20; k++) begin
         run_frame($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 2**AW - 1)), DW'($urandom_range(0, 2**DW - 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      check("miso_low_when_off", 32'(bad_miso), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
